// File: rtl/multdiv_pkg.sv
// Shared constants, state encoding and helpers for the multi-cycle multiply/divide unit.
package multdiv_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_ITERS = 32;
  localparam int unsigned PROD_W   = 2 * MD_WIDTH;
  localparam int unsigned REM_W    = MD_WIDTH + 1;
  localparam int unsigned CNT_W    = $clog2(MD_ITERS);

  localparam logic [4:0] OP_MULT = 5'b00110;
  localparam logic [4:0] OP_DIV  = 5'b00111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // Unsigned magnitude; the most negative value maps onto itself as unsigned 2^(W-1).
  function automatic logic [MD_WIDTH-1:0] md_abs(input logic [MD_WIDTH-1:0] x);
    return x[MD_WIDTH-1] ? MD_WIDTH'(-x) : x;
  endfunction

endpackage

// File: rtl/multdiv_step.sv
// One shift-add multiply or restoring divide iteration, purely combinational.
module multdiv_step
  import multdiv_pkg::*;
(
  input  logic                is_div_i,
  input  logic [PROD_W-1:0]   acc_i,
  input  logic [REM_W-1:0]    rem_i,
  input  logic [MD_WIDTH-1:0] opnd_i,
  output logic [PROD_W-1:0]   acc_o,
  output logic [REM_W-1:0]    rem_o
);

  logic [REM_W-1:0] sum;
  logic [REM_W:0]   shifted;
  logic [REM_W-1:0] diff;
  logic             fits;

  always_comb begin
    // Multiply: acc = {upper, multiplier}; add multiplicand into upper when lsb set, then shift right.
    sum     = {1'b0, acc_i[PROD_W-1:MD_WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Divide: acc[31:0] holds dividend bits shifting out and quotient bits shifting in.
    shifted = {rem_i, acc_i[MD_WIDTH-1]};
    fits    = shifted >= {2'b00, opnd_i};
    diff    = REM_W'(shifted - {2'b00, opnd_i});
    acc_o   = acc_i;
    rem_o   = rem_i;
    if (is_div_i) begin
      rem_o = fits ? diff : shifted[REM_W-1:0];
      acc_o = {acc_i[PROD_W-1:MD_WIDTH], acc_i[MD_WIDTH-2:0], fits};
    end else begin
      acc_o = {sum, acc_i[MD_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/multdiv_sequencer.sv
// Multi-cycle signed multiply/divide with its own sequencer; stalls the pipeline while busy
// and issues a one-cycle result/exception pulse for writeback.
module multdiv_sequencer
  import multdiv_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [MD_WIDTH-1:0] data_operandA,
  input  logic [MD_WIDTH-1:0] data_operandB,
  input  logic                ctrl_MULT,
  input  logic                ctrl_DIV,
  output logic [MD_WIDTH-1:0] data_result,
  output logic                data_exception,
  output logic                data_resultRDY,
  output logic                ctrl_stall
);

  md_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PROD_W-1:0]   acc_q, acc_d, step_acc;
  logic [REM_W-1:0]    rem_q, rem_d, step_rem;
  logic [MD_WIDTH-1:0] opnd_q, opnd_d;
  logic                is_div_q, is_div_d;
  logic                neg_q, neg_d;
  logic                div0_q, div0_d;
  logic                ovf_q, ovf_d;
  logic [MD_WIDTH-1:0] result_q, result_d;
  logic                exc_q, exc_d;
  logic                rdy_q, rdy_d;
  logic                start;
  logic [PROD_W-1:0]   prod;
  logic [MD_WIDTH:0]   prod_hi;

  assign start = ctrl_MULT | ctrl_DIV;

  multdiv_step u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .rem_i    (rem_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc),
    .rem_o    (step_rem)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == CNT_W'(MD_ITERS - 1)) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl_stall = 1'b0;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    div0_d     = div0_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    exc_d      = exc_q;
    rdy_d      = 1'b0;
    // Negating the whole accumulator also yields the signed quotient in the low word.
    prod       = neg_q ? PROD_W'(-acc_q) : acc_q;
    prod_hi    = prod[PROD_W-1:MD_WIDTH-1];
    unique case (state_q)
      ST_IDLE: begin
        ctrl_stall = start & ~reset;
        if (start) begin
          is_div_d = ~ctrl_MULT;
          neg_d    = data_operandA[MD_WIDTH-1] ^ data_operandB[MD_WIDTH-1];
          div0_d   = data_operandB == '0;
          ovf_d    = (data_operandA == {1'b1, {(MD_WIDTH-1){1'b0}}}) & (&data_operandB);
          opnd_d   = ctrl_MULT ? md_abs(data_operandA) : md_abs(data_operandB);
          acc_d    = {{MD_WIDTH{1'b0}}, ctrl_MULT ? md_abs(data_operandB) : md_abs(data_operandA)};
          rem_d    = '0;
          cnt_d    = '0;
        end
      end
      ST_RUN: begin
        ctrl_stall = ~reset;
        acc_d      = step_acc;
        rem_d      = step_rem;
        cnt_d      = CNT_W'(cnt_q + 1'b1);
      end
      ST_FIX: begin
        ctrl_stall = ~reset;
        rdy_d      = 1'b1;
        if (is_div_q) begin
          result_d = div0_q ? '0 : prod[MD_WIDTH-1:0];
          exc_d    = div0_q | ovf_q;
        end else begin
          result_d = prod[MD_WIDTH-1:0];
          exc_d    = ~((&prod_hi) | (~|prod_hi));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule
